// File: rtl/counter_mod_n.sv
// -----------------------------------------------------------------------------
// counter_mod_n
//
// Purpose:
//    Modulo-N up/down counter used as a digit stage in alarm-clock chains
//    (seconds/minutes 0-9 and 0-5, hours 0-9 and 0-2). A digit advances on
//    Up or Down when Enable is high, can be loaded synchronously, and reports
//    wrap-around through the combinational CARRY/BORROW outputs so the next
//    digit can step in the same clock cycle. Out-of-range loads force the
//    count to 0 and raise LD_ERR for exactly one cycle.
//
// Parameters:
//    WIDTH  bit width of COUNT and IN_VAL (2**WIDTH >= MOD)
//    Modulus parameter: COUNT stays within 0..MOD-1 (MOD >= 2)
//    WRAP   1 = wrap at the limits, 0 = saturate at MOD-1 / 0
//
// Ports:
//    Clk     in   1      clock, all state changes on the rising edge
//    Clr     in   1      asynchronous active-low reset
//    Enable  in   1      qualifies LD, Up and Down; 0 = hold
//    LD      in   1      synchronous load of IN_VAL
//    Up      in   1      count up one step
//    Down    in   1      count down one step
//    IN_VAL  in   WIDTH  load value
//    COUNT   out  WIDTH  registered count value
//    CARRY   out  1      up-step requested while COUNT == MOD-1
//    BORROW  out  1      down-step requested while COUNT == 0
//    LD_ERR  out  1      one-cycle pulse after an out-of-range load
// -----------------------------------------------------------------------------
module counter_mod_n #(
   parameter int WIDTH = 4,
   parameter int MOD   = 10,
   parameter bit WRAP  = 1'b1
) (
   input  logic             Clk,
   input  logic             Clr,
   input  logic             Enable,
   input  logic             LD,
   input  logic             Up,
   input  logic             Down,
   input  logic [WIDTH-1:0] IN_VAL,
   output logic [WIDTH-1:0] COUNT,
   output logic             CARRY,
   output logic             BORROW,
   output logic             LD_ERR
);

   // The top count value always fits in WIDTH bits, whereas MOD itself does
   // not when MOD == 2**WIDTH, so the load range check widens by one bit instead.
   localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MOD - 1);
   localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH + 1)'(MOD);
   localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

   logic [WIDTH-1:0] next_count;
   logic             next_ld_err;
   logic             at_max;
   logic             at_zero;
   logic             in_range;

   // Limit detection shared by the next-state logic and the cascade outputs.
   always_comb begin
      at_max   = (COUNT == MAX_COUNT);
      at_zero  = (COUNT == '0);
      in_range = ({1'b0, IN_VAL} < MOD_EXT);
   end

   // Next-state selection in priority order: disabled, load, conflicting
   // Up+Down, up step, down step, idle. LD_ERR only survives the cycle that
   // follows a bad load, so every other path clears it.
   always_comb begin
      next_count  = COUNT;
      next_ld_err = 1'b0;
      if (!Enable) begin
         next_count = COUNT;
      end else if (LD) begin
         if (in_range) begin
            next_count = IN_VAL;
         end else begin
            next_count  = '0;
            next_ld_err = 1'b1;
         end
      end else if (Up && Down) begin
         next_count = COUNT;
      end else if (Up) begin
         if (!at_max) begin
            next_count = COUNT + ONE;
         end else if (WRAP) begin
            next_count = '0;
         end
      end else if (Down) begin
         if (!at_zero) begin
            next_count = COUNT - ONE;
         end else if (WRAP) begin
            next_count = MAX_COUNT;
         end
      end
   end

   // Count register and load-error flag; Clr low clears both immediately.
   always_ff @(posedge Clk or negedge Clr) begin
      if (!Clr) begin
         COUNT  <= '0;
         LD_ERR <= 1'b0;
      end else begin
         COUNT  <= next_count;
         LD_ERR <= next_ld_err;
      end
   end

   // Cascade outputs are combinational so the next digit can be enabled in
   // the same cycle. They fire on the attempt even when WRAP=0 saturates.
   always_comb begin
      CARRY  = Enable & Up & ~Down & ~LD & at_max;
      BORROW = Enable & Down & ~Up & ~LD & at_zero;
   end

endmodule

// File: tb/tb_counter_mod_n.sv
// -----------------------------------------------------------------------------
// tb_counter_mod_n
//
// Purpose:
//    Directed testbench for counter_mod_n. Instances: a (MOD=10, wrap),
//    b (MOD=6, wrap), c (MOD=6, saturate), d (MOD=16 in 4 bits, wrap) and a
//    units/tens cascade (MOD=10 feeding MOD=6 through CARRY).
// -----------------------------------------------------------------------------
module tb_counter_mod_n;

   logic       Clk;
   logic       Clr;

   logic       a_en, a_ld, a_up, a_dn;
   logic [3:0] a_in, a_cnt;
   logic       a_carry, a_borrow, a_err;

   logic       b_en, b_ld, b_up, b_dn;
   logic [3:0] b_in, b_cnt;
   logic       b_carry, b_borrow, b_err;

   logic       c_en, c_ld, c_up, c_dn;
   logic [3:0] c_in, c_cnt;
   logic       c_carry, c_borrow, c_err;

   logic       d_en, d_ld, d_up, d_dn;
   logic [3:0] d_in, d_cnt;
   logic       d_carry, d_borrow, d_err;

   logic       u_en, u_up;
   logic [3:0] u_cnt, t_cnt;
   logic       u_carry, u_borrow, u_err;
   logic       t_carry, t_borrow, t_err;

   int         checks;
   int         errors;

   counter_mod_n #(.WIDTH(4), .MOD(10), .WRAP(1'b1)) dut_a (
      .Clk(Clk), .Clr(Clr), .Enable(a_en), .LD(a_ld), .Up(a_up), .Down(a_dn),
      .IN_VAL(a_in), .COUNT(a_cnt), .CARRY(a_carry), .BORROW(a_borrow), .LD_ERR(a_err));

   counter_mod_n #(.WIDTH(4), .MOD(6), .WRAP(1'b1)) dut_b (
      .Clk(Clk), .Clr(Clr), .Enable(b_en), .LD(b_ld), .Up(b_up), .Down(b_dn),
      .IN_VAL(b_in), .COUNT(b_cnt), .CARRY(b_carry), .BORROW(b_borrow), .LD_ERR(b_err));

   counter_mod_n #(.WIDTH(4), .MOD(6), .WRAP(1'b0)) dut_c (
      .Clk(Clk), .Clr(Clr), .Enable(c_en), .LD(c_ld), .Up(c_up), .Down(c_dn),
      .IN_VAL(c_in), .COUNT(c_cnt), .CARRY(c_carry), .BORROW(c_borrow), .LD_ERR(c_err));

   counter_mod_n #(.WIDTH(4), .MOD(16), .WRAP(1'b1)) dut_d (
      .Clk(Clk), .Clr(Clr), .Enable(d_en), .LD(d_ld), .Up(d_up), .Down(d_dn),
      .IN_VAL(d_in), .COUNT(d_cnt), .CARRY(d_carry), .BORROW(d_borrow), .LD_ERR(d_err));

   counter_mod_n #(.WIDTH(4), .MOD(10), .WRAP(1'b1)) dut_units (
      .Clk(Clk), .Clr(Clr), .Enable(u_en), .LD(1'b0), .Up(u_up), .Down(1'b0),
      .IN_VAL(4'd0), .COUNT(u_cnt), .CARRY(u_carry), .BORROW(u_borrow), .LD_ERR(u_err));

   counter_mod_n #(.WIDTH(4), .MOD(6), .WRAP(1'b1)) dut_tens (
      .Clk(Clk), .Clr(Clr), .Enable(u_carry), .LD(1'b0), .Up(1'b1), .Down(1'b0),
      .IN_VAL(4'd0), .COUNT(t_cnt), .CARRY(t_carry), .BORROW(t_borrow), .LD_ERR(t_err));

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Advance to 1 time unit after the next rising edge, where inputs are
   // changed and registered outputs are sampled.
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Clr asserted before the first clock edge must clear every instance.
   task automatic test_reset();
      Clr = 1'b1;
      a_en = 0; a_ld = 0; a_up = 0; a_dn = 0; a_in = 0;
      b_en = 0; b_ld = 0; b_up = 0; b_dn = 0; b_in = 0;
      c_en = 0; c_ld = 0; c_up = 0; c_dn = 0; c_in = 0;
      d_en = 0; d_ld = 0; d_up = 0; d_dn = 0; d_in = 0;
      u_en = 0; u_up = 0;
      #2 Clr = 1'b0;
      #1;
      checks++;
      if (a_cnt !== 4'd0 || b_cnt !== 4'd0 || c_cnt !== 4'd0 || d_cnt !== 4'd0) begin
         errors++;
         $display("[TB] FAIL reset_count: got a=%0d b=%0d c=%0d d=%0d want all 0", a_cnt, b_cnt, c_cnt, d_cnt);
      end
      checks++;
      if (a_err !== 1'b0 || b_err !== 1'b0 || u_cnt !== 4'd0 || t_cnt !== 4'd0) begin
         errors++;
         $display("[TB] FAIL reset_misc: got a_err=%0b b_err=%0b units=%0d tens=%0d want 0", a_err, b_err, u_cnt, t_cnt);
      end
      tick();
      Clr = 1'b1;
      tick();
   endtask

   // Decade counter with wrap: twelve up-steps walk 0..9,0,1 and land on 2;
   // CARRY only at 9.
   task automatic test_up_wrap();
      int exp_cnt;
      exp_cnt = 0;
      a_en = 1; a_up = 1;
      for (int i = 0; i < 12; i++) begin
         #1;
         checks++;
         if (a_cnt !== 4'(exp_cnt)) begin
            errors++;
            $display("[TB] FAIL up_count step %0d: got %0d want %0d", i, a_cnt, exp_cnt);
         end
         checks++;
         if (a_carry !== (exp_cnt == 9)) begin
            errors++;
            $display("[TB] FAIL up_carry step %0d: got %0b want %0b", i, a_carry, (exp_cnt == 9));
         end
         tick();
         exp_cnt = (exp_cnt == 9) ? 0 : exp_cnt + 1;
      end
      checks++;
      if (a_cnt !== 4'd2) begin
         errors++;
         $display("[TB] FAIL up_final: got %0d want 2", a_cnt);
      end
      a_en = 0; a_up = 0;
   endtask

   // Modulo-6 instances: down from 0 wraps to 5 (wrap) or holds 0 (saturate);
   // up at 5 holds with WRAP=0. CARRY/BORROW flag the attempt in both modes.
   task automatic test_down_and_saturate();
      b_en = 1; b_dn = 1;
      #1;
      checks++;
      if (b_borrow !== 1'b1) begin
         errors++;
         $display("[TB] FAIL wrap_borrow: got %0b want 1", b_borrow);
      end
      tick();
      checks++;
      if (b_cnt !== 4'd5) begin
         errors++;
         $display("[TB] FAIL wrap_down: got %0d want 5", b_cnt);
      end
      #1;
      checks++;
      if (b_borrow !== 1'b0) begin
         errors++;
         $display("[TB] FAIL borrow_at_5: got %0b want 0", b_borrow);
      end
      tick();
      checks++;
      if (b_cnt !== 4'd4) begin
         errors++;
         $display("[TB] FAIL down_step: got %0d want 4", b_cnt);
      end
      b_en = 0; b_dn = 0;

      c_en = 1; c_dn = 1;
      #1;
      checks++;
      if (c_borrow !== 1'b1) begin
         errors++;
         $display("[TB] FAIL sat_borrow: got %0b want 1", c_borrow);
      end
      tick();
      checks++;
      if (c_cnt !== 4'd0) begin
         errors++;
         $display("[TB] FAIL sat_down: got %0d want 0", c_cnt);
      end
      c_dn = 0; c_ld = 1; c_in = 4'd5;
      tick();
      c_ld = 0; c_up = 1;
      #1;
      checks++;
      if (c_carry !== 1'b1) begin
         errors++;
         $display("[TB] FAIL sat_carry: got %0b want 1", c_carry);
      end
      tick();
      checks++;
      if (c_cnt !== 4'd5) begin
         errors++;
         $display("[TB] FAIL sat_up: got %0d want 5", c_cnt);
      end
      c_up = 0; c_dn = 1;
      tick();
      checks++;
      if (c_cnt !== 4'd4) begin
         errors++;
         $display("[TB] FAIL sat_down_step: got %0d want 4", c_cnt);
      end
      c_en = 0; c_dn = 0;
   endtask

   // Loads: in range, out of range (including IN_VAL==MOD), one-cycle
   // LD_ERR, and LD beating Up in the same cycle.
   task automatic test_load();
      a_en = 1; a_ld = 1; a_in = 4'd7;
      tick();
      checks++;
      if (a_cnt !== 4'd7 || a_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL load_7: got cnt=%0d err=%0b want 7/0", a_cnt, a_err);
      end
      a_in = 4'd12;
      tick();
      checks++;
      if (a_cnt !== 4'd0 || a_err !== 1'b1) begin
         errors++;
         $display("[TB] FAIL load_12: got cnt=%0d err=%0b want 0/1", a_cnt, a_err);
      end
      a_ld = 0;
      tick();
      checks++;
      if (a_err !== 1'b0 || a_cnt !== 4'd0) begin
         errors++;
         $display("[TB] FAIL err_pulse: got cnt=%0d err=%0b want 0/0", a_cnt, a_err);
      end
      a_ld = 1; a_in = 4'd10;
      tick();
      checks++;
      if (a_err !== 1'b1) begin
         errors++;
         $display("[TB] FAIL load_mod: got err=%0b want 1", a_err);
      end
      a_in = 4'd9;
      tick();
      a_in = 4'd3; a_up = 1;
      #1;
      checks++;
      if (a_carry !== 1'b0) begin
         errors++;
         $display("[TB] FAIL ld_up_carry: got %0b want 0", a_carry);
      end
      tick();
      checks++;
      if (a_cnt !== 4'd3 || a_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL ld_up: got cnt=%0d err=%0b want 3/0", a_cnt, a_err);
      end
      a_en = 0; a_ld = 0; a_up = 0;
   endtask

   // Conflicting Up+Down and a disabled load must both leave COUNT alone
   // and keep CARRY/BORROW low, even at the limits.
   task automatic test_hold();
      a_en = 1; a_ld = 1; a_in = 4'd9;
      tick();
      a_ld = 0; a_up = 1; a_dn = 1;
      #1;
      checks++;
      if (a_carry !== 1'b0 || a_borrow !== 1'b0) begin
         errors++;
         $display("[TB] FAIL updown_flags: got carry=%0b borrow=%0b want 0/0", a_carry, a_borrow);
      end
      tick();
      checks++;
      if (a_cnt !== 4'd9) begin
         errors++;
         $display("[TB] FAIL updown_hold: got %0d want 9", a_cnt);
      end
      a_en = 0; a_ld = 1; a_in = 4'd2; a_dn = 0;
      #1;
      checks++;
      if (a_carry !== 1'b0 || a_borrow !== 1'b0) begin
         errors++;
         $display("[TB] FAIL disabled_flags: got carry=%0b borrow=%0b want 0/0", a_carry, a_borrow);
      end
      tick();
      checks++;
      if (a_cnt !== 4'd9 || a_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL disabled_hold: got cnt=%0d err=%0b want 9/0", a_cnt, a_err);
      end
      a_ld = 0; a_up = 0;
   endtask

   // Full-range case (MOD == 2**WIDTH): 15 is a legal load and 15 -> 0 wraps
   // without overflow.
   task automatic test_full_range();
      d_en = 1; d_ld = 1; d_in = 4'd15;
      tick();
      checks++;
      if (d_cnt !== 4'd15 || d_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL full_load: got cnt=%0d err=%0b want 15/0", d_cnt, d_err);
      end
      d_ld = 0; d_up = 1;
      #1;
      checks++;
      if (d_carry !== 1'b1) begin
         errors++;
         $display("[TB] FAIL full_carry: got %0b want 1", d_carry);
      end
      tick();
      checks++;
      if (d_cnt !== 4'd0) begin
         errors++;
         $display("[TB] FAIL full_wrap_up: got %0d want 0", d_cnt);
      end
      d_up = 0; d_dn = 1;
      tick();
      checks++;
      if (d_cnt !== 4'd15) begin
         errors++;
         $display("[TB] FAIL full_wrap_down: got %0d want 15", d_cnt);
      end
      d_en = 0; d_dn = 0;
   endtask

   // Clr pulsed low between edges clears COUNT and LD_ERR immediately;
   // counting restarts from 0 after release.
   task automatic test_async_clear();
      a_en = 1; a_ld = 1; a_in = 4'd8;
      b_en = 1; b_ld = 1; b_in = 4'd7;
      tick();
      checks++;
      if (a_cnt !== 4'd8 || b_err !== 1'b1) begin
         errors++;
         $display("[TB] FAIL pre_clear: got a_cnt=%0d b_err=%0b want 8/1", a_cnt, b_err);
      end
      a_en = 0; a_ld = 0; b_en = 0; b_ld = 0;
      #2 Clr = 1'b0;
      #1;
      checks++;
      if (a_cnt !== 4'd0 || b_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL async_clear: got a_cnt=%0d b_err=%0b want 0/0", a_cnt, b_err);
      end
      #2 Clr = 1'b1;
      a_en = 1; a_up = 1;
      tick();
      checks++;
      if (a_cnt !== 4'd1) begin
         errors++;
         $display("[TB] FAIL restart: got %0d want 1", a_cnt);
      end
      a_en = 0; a_up = 0;
   endtask

   // Units (MOD=10) CARRY enables tens (MOD=6): 59 steps -> 59, 60th -> 00.
   task automatic test_cascade();
      int exp_u;
      int exp_t;
      exp_u = 0;
      exp_t = 0;
      u_en = 1; u_up = 1;
      for (int s = 1; s <= 60; s++) begin
         tick();
         if (exp_u == 9) begin
            exp_u = 0;
            exp_t = (exp_t == 5) ? 0 : exp_t + 1;
         end else begin
            exp_u = exp_u + 1;
         end
         checks++;
         if (u_cnt !== 4'(exp_u) || t_cnt !== 4'(exp_t)) begin
            errors++;
            $display("[TB] FAIL cascade step %0d: got %0d%0d want %0d%0d", s, t_cnt, u_cnt, exp_t, exp_u);
         end
         if (s == 59) begin
            checks++;
            if (u_carry !== 1'b1 || t_carry !== 1'b1) begin
               errors++;
               $display("[TB] FAIL cascade_carry at 59: got units=%0b tens=%0b want 1/1", u_carry, t_carry);
            end
         end
      end
      u_en = 0; u_up = 0;
   endtask

   // Test sequence and summary.
   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_up_wrap();
      test_down_and_saturate();
      test_load();
      test_hold();
      test_full_range();
      test_async_clear();
      test_cascade();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
